addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Shares one 16-bit saturating add/sub unit (addsub_16bit) between two requesters, e.g. the ALU issue path and the address/PADDSB sequencer.
- Arbitrates round-robin and registers the accepted operands so the shared unit's inputs are stable for a full cycle.
- Captures the sum/error and returns it through a valid/ready response channel tagged with the requester ID.

Parameters:
- WIDTH, 16, operand/result width; must match the shared add/sub unit.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_vld  input  2  bit i: requester i has an operation pending
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_sub, req0_pad  input  1  requester 0 subtract / nibble-pad mode
- req1_a, req1_b  input  WIDTH  requester 1 operands
- req1_sub, req1_pad  input  1  requester 1 subtract / nibble-pad mode
- req_gnt  output  2  one-hot pulse: operation of requester i accepted
- au_a, au_b  output  WIDTH  operands to shared add/sub unit
- au_sub, au_pad  output  1  mode to shared add/sub unit
- au_sum  input  WIDTH  shared unit result (combinational from au_*)
- au_err  input  1  shared unit overflow/saturation flag
- rsp_vld  output  1  response valid
- rsp_rdy  input  1  response consumed this cycle when high with rsp_vld
- rsp_id  output  1  requester that owns the response
- rsp_sum  output  WIDTH  registered result
- rsp_err  output  1  registered error flag
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; req_gnt=0; rsp_vld=0; rsp_id=0; rsp_sum=0; rsp_err=0.
  - au_a=au_b=0; au_sub=au_pad=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- States:
  - IDLE:
    - If req_vld!=0, select a winner: the sole requester, or ~last if both request.
    - Latch the winner's a/b/sub/pad into au_*, set req_gnt[winner]=1, set last=winner, go to CALC.
    - Otherwise stay in IDLE.
  - CALC (exactly one cycle):
    - au_* are stable and req_vld is ignored.
    - At the clock edge, register au_sum→rsp_sum and au_err→rsp_err; rsp_id=last; rsp_vld=1; go to RESP.
  - RESP:
    - Hold rsp_vld and rsp_* stable until rsp_rdy=1.
    - On rsp_vld&rsp_rdy with req_vld!=0, arbitrate exactly as in IDLE in the same cycle: latch operands, pulse req_gnt, clear rsp_vld, go to CALC.
    - On rsp_vld&rsp_rdy with req_vld=0, clear rsp_vld and go to IDLE.
- req_gnt:
  - Registered; high exactly during the CALC cycle, for one cycle only.
  - A requester must hold req_vld and its operands stable until it sees gnt, then deassert in that cycle if it has no further operation.
- Latency and throughput:
  - req_vld sampled at edge T in IDLE; gnt and au_* valid in cycle T+1; rsp_vld high from cycle T+2.
  - Back-to-back throughput is 1 op per 2 cycles when rsp_rdy stays high.
- The arbiter passes sub/pad through unchanged. All saturation/pad arithmetic belongs to the shared unit; rsp_sum/rsp_err are that unit's outputs exactly.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Reset asserted in any state returns the block to IDLE at the next edge. Any in-flight response is dropped (rsp_vld=0) and no gnt is issued that cycle.

Optional Feature:
- Macro: ADDSUB_ARB_CNT_EN
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each), plus err_cnt (16 bits).
  - gnt_cnt0/gnt_cnt1 increment on each req_gnt[i] pulse.
  - err_cnt increments when a response with rsp_err=1 is consumed.
  - All counters saturate at 0xFFFF and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_vld=01 with req0 0x0003+0x0004 add, rsp_rdy=1: gnt=01 one cycle after the request; rsp_vld one cycle later with rsp_sum=0x0007, rsp_err=0, rsp_id=0.
- After reset, req_vld=11 held continuously, rsp_rdy=1: grant order 0,1,0,1; rsp_id alternates; a new gnt every 2 cycles.
- req1 sub 0x8000-0x0001 with pad=0: rsp_sum=0x8000, rsp_err=1, rsp_id=1.
- Backpressure: rsp_rdy=0 for 5 cycles with req0 pending. Required:
  - rsp_vld/rsp_sum stay stable throughout.
  - No gnt during the stall.
  - On the cycle rsp_rdy=1, gnt=01 appears the next cycle and rsp_vld drops.
- rst_n=0 during CALC: next cycle rsp_vld=0, busy=0, gnt=0. A subsequent tie grants requester 0.
- With ADDSUB_ARB_CNT_EN defined, 3 req0 ops and 2 req1 ops of which one saturates: gnt_cnt0=3, gnt_cnt1=2, err_cnt=1.

Source files
------------

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between the requesters and the add/sub arbiter.
interface addsub_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       req_vld;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic             req0_pad;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    logic             req1_pad;
    logic [1:0]       req_gnt;
    logic             rsp_vld;
    logic             rsp_rdy;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_err;

    modport master (
        output req_vld, req0_a, req0_b, req0_sub, req0_pad,
        output req1_a, req1_b, req1_sub, req1_pad, rsp_rdy,
        input  req_gnt, rsp_vld, rsp_id, rsp_sum, rsp_err
    );

    modport slave (
        input  req_vld, req0_a, req0_b, req0_sub, req0_pad,
        input  req1_a, req1_b, req1_sub, req1_pad, rsp_rdy,
        output req_gnt, rsp_vld, rsp_id, rsp_sum, rsp_err
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one saturating add/sub unit between two requesters.
// Optional grant/error counters are enabled with `define ADDSUB_ARB_CNT_EN.
module addsub_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    addsub_arbiter_if.slave  bus,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_sub,
    output logic             au_pad,
    input  logic [WIDTH-1:0] au_sum,
    input  logic             au_err,
`ifdef ADDSUB_ARB_CNT_EN
    output logic [15:0]      gnt_cnt0,
    output logic [15:0]      gnt_cnt1,
    output logic [15:0]      err_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r, state_nxt;
    logic             last_r, last_nxt;
    logic [1:0]       gnt_r, gnt_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt;
    logic             sub_nxt, pad_nxt;
    logic             rsp_vld_r, rsp_vld_nxt;
    logic             rsp_id_r, rsp_id_nxt;
    logic [WIDTH-1:0] rsp_sum_r, rsp_sum_nxt;
    logic             rsp_err_r, rsp_err_nxt;
    logic             win_s;
    logic             take_s;

    assign bus.req_gnt = gnt_r;
    assign bus.rsp_vld = rsp_vld_r;
    assign bus.rsp_id  = rsp_id_r;
    assign bus.rsp_sum = rsp_sum_r;
    assign bus.rsp_err = rsp_err_r;
    assign busy        = (state_r != ST_IDLE);

    // Winner selection: the sole requester, or the one not served last on a tie.
    always_comb begin
        win_s = 1'b0;
        if (bus.req_vld == 2'b11) begin
            win_s = ~last_r;
        end else begin
            win_s = bus.req_vld[1];
        end
    end

    // Next-state and next-output logic for the whole FSM.
    always_comb begin
        state_nxt   = state_r;
        last_nxt    = last_r;
        gnt_nxt     = 2'b00;
        a_nxt       = au_a;
        b_nxt       = au_b;
        sub_nxt     = au_sub;
        pad_nxt     = au_pad;
        rsp_vld_nxt = rsp_vld_r;
        rsp_id_nxt  = rsp_id_r;
        rsp_sum_nxt = rsp_sum_r;
        rsp_err_nxt = rsp_err_r;
        take_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                take_s = (bus.req_vld != 2'b00);
            end
            ST_CALC: begin
                rsp_sum_nxt = au_sum;
                rsp_err_nxt = au_err;
                rsp_id_nxt  = last_r;
                rsp_vld_nxt = 1'b1;
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_rdy) begin
                    rsp_vld_nxt = 1'b0;
                    take_s      = (bus.req_vld != 2'b00);
                    state_nxt   = ST_IDLE;
                end else begin
                    rsp_vld_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                rsp_vld_nxt = 1'b0;
            end
        endcase

        // Accepting a request overrides the IDLE fallback chosen above.
        if (take_s) begin
            if (win_s) begin
                a_nxt   = bus.req1_a;
                b_nxt   = bus.req1_b;
                sub_nxt = bus.req1_sub;
                pad_nxt = bus.req1_pad;
                gnt_nxt = 2'b10;
            end else begin
                a_nxt   = bus.req0_a;
                b_nxt   = bus.req0_b;
                sub_nxt = bus.req0_sub;
                pad_nxt = bus.req0_pad;
                gnt_nxt = 2'b01;
            end
            last_nxt  = win_s;
            state_nxt = ST_CALC;
        end else begin
            gnt_nxt = 2'b00;
        end
    end

    // State, operand and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            last_r    <= 1'b1;
            gnt_r     <= 2'b00;
            au_a      <= {WIDTH{1'b0}};
            au_b      <= {WIDTH{1'b0}};
            au_sub    <= 1'b0;
            au_pad    <= 1'b0;
            rsp_vld_r <= 1'b0;
            rsp_id_r  <= 1'b0;
            rsp_sum_r <= {WIDTH{1'b0}};
            rsp_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            last_r    <= last_nxt;
            gnt_r     <= gnt_nxt;
            au_a      <= a_nxt;
            au_b      <= b_nxt;
            au_sub    <= sub_nxt;
            au_pad    <= pad_nxt;
            rsp_vld_r <= rsp_vld_nxt;
            rsp_id_r  <= rsp_id_nxt;
            rsp_sum_r <= rsp_sum_nxt;
            rsp_err_r <= rsp_err_nxt;
        end
    end

`ifdef ADDSUB_ARB_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating grant and consumed-error counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_cnt0 <= 16'd0;
            gnt_cnt1 <= 16'd0;
            err_cnt  <= 16'd0;
        end else begin
            gnt_cnt0 <= gnt_r[0] ? sat_inc(gnt_cnt0) : gnt_cnt0;
            gnt_cnt1 <= gnt_r[1] ? sat_inc(gnt_cnt1) : gnt_cnt1;
            err_cnt  <= (rsp_vld_r && bus.rsp_rdy && rsp_err_r) ? sat_inc(err_cnt) : err_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter with a signed saturating add/sub model.
module tb_addsub_arbiter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] au_a, au_b, au_sum;
    logic             au_sub, au_pad, au_err;
    logic             busy;
    int               total;
    int               bad;
`ifdef ADDSUB_ARB_CNT_EN
    logic [15:0]      gnt_cnt0, gnt_cnt1, err_cnt;
`endif

    addsub_arbiter_if #(.WIDTH(WIDTH)) bus ();

    addsub_arbiter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .au_a     (au_a),
        .au_b     (au_b),
        .au_sub   (au_sub),
        .au_pad   (au_pad),
        .au_sum   (au_sum),
        .au_err   (au_err),
`ifdef ADDSUB_ARB_CNT_EN
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1),
        .err_cnt  (err_cnt),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared unit: signed saturating add/sub.
    always_comb begin
        logic signed [16:0] r;
        if (au_sub) r = $signed({au_a[15], au_a}) - $signed({au_b[15], au_b});
        else        r = $signed({au_a[15], au_a}) + $signed({au_b[15], au_b});
        if (r > 17'sd32767) begin
            au_sum = 16'h7FFF; au_err = 1'b1;
        end else if (r < -17'sd32768) begin
            au_sum = 16'h8000; au_err = 1'b1;
        end else begin
            au_sum = r[15:0]; au_err = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_vld = 2'b00;
        bus.rsp_rdy = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input logic id, input logic [15:0] a, input logic [15:0] b, input logic sub);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
        end
    endtask

    // One single-requester operation with rsp_rdy held high.
    task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] exp_sum, input logic exp_err);
        set_req(id, a, b, sub);
        bus.req_vld = id ? 2'b10 : 2'b01;
        bus.rsp_rdy = 1'b1;
        tick();
        chk("op_gnt", {30'd0, bus.req_gnt}, id ? 32'd2 : 32'd1);
        chk("op_au_a", {16'd0, au_a}, {16'd0, a});
        chk("op_au_sub", {31'd0, au_sub}, {31'd0, sub});
        bus.req_vld = 2'b00;
        tick();
        chk("op_rsp_vld", {31'd0, bus.rsp_vld}, 32'd1);
        chk("op_rsp_sum", {16'd0, bus.rsp_sum}, {16'd0, exp_sum});
        chk("op_rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
        chk("op_rsp_id", {31'd0, bus.rsp_id}, {31'd0, id});
        chk("op_gnt_pulse", {30'd0, bus.req_gnt}, 32'd0);
        tick();
        chk("op_drain_vld", {31'd0, bus.rsp_vld}, 32'd0);
        chk("op_drain_busy", {31'd0, busy}, 32'd0);
    endtask

    logic [1:0]  tie_gnt [8];
    logic [15:0] tie_sum [8];

    initial begin
        total = 0;
        bad = 0;
        bus.req0_pad = 1'b0;
        bus.req1_pad = 1'b0;
        set_req(1'b0, 16'd0, 16'd0, 1'b0);
        set_req(1'b1, 16'd0, 16'd0, 1'b0);

        // Reset state
        do_reset();
        chk("rst_gnt", {30'd0, bus.req_gnt}, 32'd0);
        chk("rst_rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        chk("rst_rsp_sum", {16'd0, bus.rsp_sum}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_au_a", {16'd0, au_a}, 32'd0);

        // Simple add from requester 0
        do_op(1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

        // Continuous tie: strict alternation, one grant every two cycles
        do_reset();
        set_req(1'b0, 16'd1, 16'd2, 1'b0);
        set_req(1'b1, 16'd10, 16'd5, 1'b1);
        tie_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        tie_sum = '{16'd0, 16'd3, 16'd0, 16'd5, 16'd0, 16'd3, 16'd0, 16'd5};
        bus.req_vld = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("tie_gnt", {30'd0, bus.req_gnt}, {30'd0, tie_gnt[i]});
            chk("tie_rsp_vld", {31'd0, bus.rsp_vld}, {31'd0, (i % 2 == 1)});
            if (i % 2 == 1) begin
                chk("tie_rsp_id", {31'd0, bus.rsp_id}, {31'd0, (i % 4 == 3)});
                chk("tie_rsp_sum", {16'd0, bus.rsp_sum}, {16'd0, tie_sum[i]});
            end
        end
        bus.req_vld = 2'b00;
        tick();
        chk("tie_drain", {31'd0, busy}, 32'd0);

        // Negative saturation from requester 1
        do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1);

        // Backpressure with a second req0 op pending
        set_req(1'b0, 16'h0100, 16'h0023, 1'b0);
        bus.req_vld = 2'b01;
        bus.rsp_rdy = 1'b0;
        tick();
        chk("bp_gnt", {30'd0, bus.req_gnt}, 32'd1);
        set_req(1'b0, 16'h0005, 16'h0006, 1'b0);
        tick();
        chk("bp_first_vld", {31'd0, bus.rsp_vld}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stall_vld", {31'd0, bus.rsp_vld}, 32'd1);
            chk("bp_stall_sum", {16'd0, bus.rsp_sum}, 32'h0123);
            chk("bp_stall_gnt", {30'd0, bus.req_gnt}, 32'd0);
        end
        bus.rsp_rdy = 1'b1;
        tick();
        chk("bp_release_gnt", {30'd0, bus.req_gnt}, 32'd1);
        chk("bp_release_vld", {31'd0, bus.rsp_vld}, 32'd0);
        chk("bp_release_au_a", {16'd0, au_a}, 32'h0005);
        bus.req_vld = 2'b00;
        tick();
        chk("bp_second_sum", {16'd0, bus.rsp_sum}, 32'h000B);
        tick();
        chk("bp_drain", {31'd0, busy}, 32'd0);

        // Reset during CALC; last served was 0 so this tie goes to 1
        set_req(1'b0, 16'd7, 16'd1, 1'b0);
        set_req(1'b1, 16'd9, 16'd1, 1'b0);
        bus.req_vld = 2'b11;
        tick();
        chk("rc_tie_before", {30'd0, bus.req_gnt}, 32'd2);
        rst_n = 1'b0;
        tick();
        chk("rc_rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
        chk("rc_busy", {31'd0, busy}, 32'd0);
        chk("rc_gnt", {30'd0, bus.req_gnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rc_tie_after", {30'd0, bus.req_gnt}, 32'd1);
        bus.req_vld = 2'b00;
        tick();
        chk("rc_sum", {16'd0, bus.rsp_sum}, 32'd8);
        tick();

`ifdef ADDSUB_ARB_CNT_EN
        // Counter feature
        do_reset();
        chk("cnt_rst", {16'd0, gnt_cnt0}, 32'd0);
        do_op(1'b0, 16'd1, 16'd1, 1'b0, 16'd2, 1'b0);
        do_op(1'b0, 16'd2, 16'd2, 1'b0, 16'd4, 1'b0);
        do_op(1'b0, 16'd9, 16'd3, 1'b1, 16'd6, 1'b0);
        do_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1);
        do_op(1'b1, 16'd5, 16'd3, 1'b1, 16'd2, 1'b0);
        chk("cnt_gnt0", {16'd0, gnt_cnt0}, 32'd3);
        chk("cnt_gnt1", {16'd0, gnt_cnt1}, 32'd2);
        chk("cnt_err", {16'd0, err_cnt}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
